geofence_poly: RTL and testbench
================================

// Module: geofence_poly
// PURPOSE
//   Point-in-convex-polygon engine for the geofence datapath; supersedes the fixed six-vertex, 10-bit unit.
//   Accepts one target point, then NV vertices in arbitrary order over an in_valid handshake.
//   Sorts the vertices counter-clockwise around vertex 0, then tests the target against every edge.
//   Emits a one-cycle valid pulse carrying is_inside.
// PARAMETERS
//   NV  6   vertex count, 3..8
//   W   10  unsigned coordinate width, 4..16
// PORTS
//   clk        in   1   clock
//   reset      in   1   reset, asynchronous, active-high
//   in_valid   in   1   X/Y carry a sample this cycle
//   X          in   W   x coordinate (target first, then vertices)
//   Y          in   W   y coordinate
//   busy       out  1   high = samples are not accepted
//   valid      out  1   one-cycle result strobe
//   is_inside  out  1   result; meaningful only while valid=1
//   on_edge    out  1   only when GEOFENCE_ON_EDGE_EN is defined
// BEHAVIOUR
//   Reset values: all outputs 0; state IDLE; vertex/target registers don't-care.
//   Accept rule: a sample is taken when in_valid && !busy. Gaps (in_valid=0) are allowed anywhere.
//   States:
//     IDLE: 1st accepted sample -> target P, go LOAD.
//     LOAD: next NV accepted samples -> v[0..NV-1]. After the NV-th: busy=1, go SORT.
//     SORT: one pair per cycle, i=1..NV-2.
//       c = cross(v[i]-v[0], v[i+1]-v[0]); if c<0, swap v[i], v[i+1].
//       At the end of a pass: any swap -> new pass; no swap -> go TEST.
//       c==0 (collinear) never swaps.
//     TEST: one edge per cycle, k=0..NV-1.
//       e_k = cross(v[k]-P, v[(k+1)%NV]-P); the index wraps NV-1 -> 0.
//       Accumulate all_pos (every e_k>0) and any_zero (some e_k==0, rest >0).
//     DONE: valid=1 for exactly one cycle, busy=0, go IDLE.
//       A sample accepted in DONE becomes the next target P.
//   cross(a,b) = a.x*b.y - b.x*a.y
//     differences: signed W+1 bits; products: 2W+2 bits; result: signed 2W+3 bits, no truncation.
//   Latency, last vertex accepted -> valid:
//     (passes)*(NV-2) + NV + 1 cycles.
//     passes <= NV-1, so worst case is (NV-1)(NV-2)+NV+1 (NV=6: 27).
//   busy: 0 in IDLE/LOAD/DONE, 1 in SORT/TEST.
//   Samples presented while busy=1 are dropped silently.
//   Reset asserted mid-LOAD/SORT/TEST aborts immediately: no valid, state IDLE.
//   Duplicate or collinear vertices: no error; the result follows the sign rules above.
//   Polygon must be convex; a non-convex input gives an unspecified is_inside but identical timing.
// CONFIGURATION
//   GEOFENCE_ON_EDGE_EN defined:
//     on_edge port present.
//     At valid: on_edge = any_zero; is_inside = all_pos | any_zero (boundary counts as inside).
//   Not defined:
//     no on_edge port; is_inside = all_pos (boundary counts as outside).
// STRUCTURE
//   Package geofence_pkg:
//     state enum {IDLE, LOAD, SORT, TEST, DONE}
//     function CROSS_W(W) = 2*W+3
//     point struct {x,y}
//   Sub-module geofence_cross: combinational signed cross product; two instances (SORT operand mux, TEST operand mux).
//   Vertex storage: NV x 2W flops, shifted on LOAD, pair-swapped in SORT.
// TESTING
//   1. NV=4: P=(5,5), square (0,0),(10,10),(10,0),(0,10) scrambled
//      -> valid after sort, is_inside=1.
//   2. Same square, P=(11,5) -> is_inside=0. P=(10,5):
//      macro off -> is_inside=0; macro on -> is_inside=1, on_edge=1.
//   3. NV=6, W=10: hexagon fed in reverse-CW order, P at centroid
//      -> is_inside=1; latency <= 27 cycles; one-cycle valid pulse.
//   4. Vertices at (0,0),(1023,0),(1023,1023), P=(1022,1)
//      -> is_inside=1, no overflow.
//   5. in_valid=1 held through SORT/TEST with junk data
//      -> ignored; the sample in the DONE cycle becomes the next P, and the next result is correct.
//   6. Reset pulsed mid-SORT -> no valid, busy=0.
//      The following full transaction completes with correct is_inside.

Source files
------------

// File: rtl/geofence_pkg.sv
// geofence_pkg: shared types and sizing helpers for the point-in-convex-polygon engine
//   state_t  controller states IDLE, LOAD, SORT, TEST, DONE
//   point_t  coordinate pair at the widest supported coordinate width (MAX_W bits)
//   CROSS_W  exact width of a signed cross product built from W-bit coordinates
package geofence_pkg;
    localparam int MAX_W = 16;

    typedef enum logic [2:0] {IDLE, LOAD, SORT, TEST, DONE} state_t;

    typedef struct packed {
        logic [MAX_W-1:0] x;
        logic [MAX_W-1:0] y;
    } point_t;

    function automatic int CROSS_W(input int w);
        return 2 * w + 3;
    endfunction
endpackage

// File: rtl/geofence_if.sv
// geofence_if: sample/result bus of the geofence engine
//   in_valid, X, Y  sample in (target first, then vertices)
//   busy            samples are dropped while high
//   valid           one-cycle result strobe
//   is_inside       result, meaningful while valid=1
//   on_edge         boundary flag, present only with GEOFENCE_ON_EDGE_EN defined
interface geofence_if #(parameter int W = 10);
    logic         in_valid;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         busy;
    logic         valid;
    logic         is_inside;
`ifdef GEOFENCE_ON_EDGE_EN
    logic         on_edge;
    modport master (output in_valid, X, Y, input busy, valid, is_inside, on_edge);
    modport slave  (input in_valid, X, Y, output busy, valid, is_inside, on_edge);
`else
    modport master (output in_valid, X, Y, input busy, valid, is_inside);
    modport slave  (input in_valid, X, Y, output busy, valid, is_inside);
`endif
endinterface

// File: rtl/geofence_cross.sv
// geofence_cross: combinational signed cross product c = ax*by - bx*ay
//   ax, ay, bx, by  signed W+1-bit coordinate differences
//   c               signed CROSS_W(W)-bit result, never truncated
import geofence_pkg::*;

module geofence_cross #(
    parameter int  W  = 10,
    localparam int CW = CROSS_W(W)
) (
    input  logic signed [W:0]    ax,
    input  logic signed [W:0]    ay,
    input  logic signed [W:0]    bx,
    input  logic signed [W:0]    by,
    output logic signed [CW-1:0] c
);
    localparam int PW = 2 * W + 2;

    logic signed [PW-1:0] p1, p2;

    assign p1 = PW'(ax) * PW'(by);
    assign p2 = PW'(bx) * PW'(ay);
    assign c  = CW'(p1) - CW'(p2);
endmodule

// File: rtl/geofence_poly.sv
// geofence_poly: point-in-convex-polygon engine
//   Takes a target point then NV vertices in any order, sorts the vertices
//   counter-clockwise around vertex 0 (bubble passes), then tests the target
//   against every edge and strobes valid with is_inside for one cycle.
//   clk    clock
//   reset  asynchronous, active-high
//   bus    geofence_if slave: in_valid/X/Y in, busy/valid/is_inside(/on_edge) out
//   Macro GEOFENCE_ON_EDGE_EN: adds on_edge and makes the boundary count as inside.
import geofence_pkg::*;

module geofence_poly #(
    parameter int NV = 6,
    parameter int W  = 10
) (
    input logic       clk,
    input logic       reset,
    geofence_if.slave bus
);
    localparam int            IW        = $clog2(NV);
    localparam int            CW        = CROSS_W(W);
    localparam logic [IW-1:0] LAST      = IW'(NV - 1);
    localparam logic [IW-1:0] PAIR_LAST = IW'(NV - 2);

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } vtx_t;

    state_t               state, state_n;
    vtx_t                 p;
    vtx_t                 v [NV];
    logic [IW-1:0]        cnt, nxt, pass;
    logic                 swapped, neg, zero, take, swp, pass_end;
    logic signed [CW-1:0] c_sort, c_test;

    function automatic logic signed [W:0] diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    assign take     = bus.in_valid && !bus.busy;
    // cnt is the pair index in SORT and the edge index in TEST; the edge after NV-1 wraps to 0
    assign nxt      = (cnt == LAST) ? '0 : cnt + IW'(1);
    assign swp      = c_sort[CW-1];
    assign pass_end = cnt == PAIR_LAST;

    geofence_cross #(.W(W)) u_sort (
        .ax(diff(v[cnt].x, v[0].x)), .ay(diff(v[cnt].y, v[0].y)),
        .bx(diff(v[nxt].x, v[0].x)), .by(diff(v[nxt].y, v[0].y)),
        .c (c_sort)
    );

    geofence_cross #(.W(W)) u_test (
        .ax(diff(v[cnt].x, p.x)), .ay(diff(v[cnt].y, p.y)),
        .bx(diff(v[nxt].x, p.x)), .by(diff(v[nxt].y, p.y)),
        .c (c_test)
    );

    assign bus.busy  = state == SORT || state == TEST;
    assign bus.valid = state == DONE;
`ifdef GEOFENCE_ON_EDGE_EN
    assign bus.is_inside = bus.valid && !neg;
    assign bus.on_edge   = bus.valid && zero && !neg;
`else
    assign bus.is_inside = bus.valid && !neg && !zero;
`endif

    // A pass with a swap triggers another, capped at NV-1 passes so that
    // even non-convex input finishes within the worst-case latency.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = take ? LOAD : IDLE;
            LOAD:    state_n = (take && cnt == LAST) ? SORT : LOAD;
            SORT:    state_n = !pass_end ? SORT : ((swapped || swp) && pass != PAIR_LAST) ? SORT : TEST;
            TEST:    state_n = (cnt == LAST) ? DONE : TEST;
            DONE:    state_n = take ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pass    <= '0;
            swapped <= 1'b0;
            neg     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                LOAD: begin
                    cnt     <= !take ? cnt : (cnt == LAST) ? IW'(1) : cnt + IW'(1);
                    pass    <= '0;
                    swapped <= 1'b0;
                end
                SORT: begin
                    cnt     <= !pass_end ? cnt + IW'(1) : (state_n == SORT) ? IW'(1) : '0;
                    pass    <= pass_end ? pass + IW'(1) : pass;
                    swapped <= !pass_end && (swapped || swp);
                    neg     <= 1'b0;
                    zero    <= 1'b0;
                end
                TEST: begin
                    cnt  <= nxt;
                    neg  <= neg || c_test[CW-1];
                    zero <= zero || c_test == '0;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Vertices shift in toward index 0, so the first vertex received is the sort pivot.
    always_ff @(posedge clk) begin
        if (take && (state == IDLE || state == DONE))
            p <= '{x: bus.X, y: bus.Y};
        if (take && state == LOAD) begin
            for (int j = 0; j < NV - 1; j++)
                v[j] <= v[j + 1];
            v[NV-1] <= '{x: bus.X, y: bus.Y};
        end
        if (state == SORT && swp) begin
            v[cnt] <= v[nxt];
            v[nxt] <= v[cnt];
        end
    end
endmodule

// File: tb/tb_geofence_poly.sv
// tb_geofence_poly: scoreboard bench for geofence_poly with NV=3, 4 and 6 (W=10)
//   Stimulus pushes the expected result from an angle-sort geometric model;
//   a negedge monitor pops and compares whenever a unit strobes valid.
module tb_geofence_poly;
    import geofence_pkg::*;

    typedef struct {
        bit ins;
        bit oe;
    } exp_t;

`ifdef GEOFENCE_ON_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t q [3][$];
    bit   pv [3];
    int   nv [3] = '{3, 4, 6};

    always #5 clk = ~clk;

    geofence_if #(.W(10)) b3 (), b4 (), b6 ();
    geofence_poly #(.NV(3), .W(10)) u3 (.clk(clk), .reset(reset), .bus(b3));
    geofence_poly #(.NV(4), .W(10)) u4 (.clk(clk), .reset(reset), .bus(b4));
    geofence_poly #(.NV(6), .W(10)) u6 (.clk(clk), .reset(reset), .bus(b6));

    function automatic point_t pt(input int x, input int y);
        return '{x: 16'(x), y: 16'(y)};
    endfunction

    task automatic put(input int d, input logic iv, input logic [9:0] x, input logic [9:0] y);
        case (d)
            0:       begin b3.in_valid = iv; b3.X = x; b3.Y = y; end
            1:       begin b4.in_valid = iv; b4.X = x; b4.Y = y; end
            default: begin b6.in_valid = iv; b6.X = x; b6.Y = y; end
        endcase
    endtask

    function automatic logic busy_of(input int d);
        return d == 0 ? b3.busy : d == 1 ? b4.busy : b6.busy;
    endfunction
    function automatic logic valid_of(input int d);
        return d == 0 ? b3.valid : d == 1 ? b4.valid : b6.valid;
    endfunction
    function automatic logic ins_of(input int d);
        return d == 0 ? b3.is_inside : d == 1 ? b4.is_inside : b6.is_inside;
    endfunction
`ifdef GEOFENCE_ON_EDGE_EN
    function automatic logic oe_of(input int d);
        return d == 0 ? b3.on_edge : d == 1 ? b4.on_edge : b6.on_edge;
    endfunction
`endif

    task automatic chk(input string name, input int d, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d want %0d", name, d, got, want);
        end
    endtask

    // Reference: order vertices by angle around their centroid (counter-clockwise),
    // then classify the target by the signs of the edge cross products.
    function automatic exp_t model(input int n, input point_t p, input point_t v[8]);
        exp_t r;
        real cx = 0.0, cy = 0.0;
        real a [8];
        int o [8];
        bit neg = 1'b0, zero = 1'b0;
        for (int i = 0; i < n; i++) begin
            cx += real'(v[i].x) / n;
            cy += real'(v[i].y) / n;
            o[i] = i;
        end
        for (int i = 0; i < n; i++)
            a[i] = $atan2(real'(v[i].y) - cy, real'(v[i].x) - cx);
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                if (a[o[j]] < a[o[i]]) begin
                    int t;
                    t = o[i]; o[i] = o[j]; o[j] = t;
                end
        for (int k = 0; k < n; k++) begin
            longint ax, ay, bx, by, e;
            ax = longint'(v[o[k]].x) - longint'(p.x);
            ay = longint'(v[o[k]].y) - longint'(p.y);
            bx = longint'(v[o[(k + 1) % n]].x) - longint'(p.x);
            by = longint'(v[o[(k + 1) % n]].y) - longint'(p.y);
            e = ax * by - bx * ay;
            neg |= e < 0;
            zero |= e == 0;
        end
        r.ins = EDGE_EN ? !neg : (!neg && !zero);
        r.oe  = EDGE_EN && zero && !neg;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (valid_of(d)) begin
                chk("pulse_width", d, int'(pv[d]), 0);
                chk("pending", d, int'(q[d].size() > 0), 1);
                if (q[d].size() > 0) begin
                    e = q[d].pop_front();
                    chk("is_inside", d, int'(ins_of(d)), int'(e.ins));
`ifdef GEOFENCE_ON_EDGE_EN
                    chk("on_edge", d, int'(oe_of(d)), int'(e.oe));
`endif
                end
            end
            pv[d] = valid_of(d);
        end
    end

    task automatic send(input int d, input point_t s);
        int n = 0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        put(d, 1'b1, s.x[9:0], s.y[9:0]);
        while (busy_of(d) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout dut%0d: busy held %0d cycles, want release", d, n);
        end
        @(negedge clk);
        put(d, 1'b0, 10'd0, 10'd0);
    endtask

    // hold=1 keeps junk on the bus while busy and presents np in the DONE cycle.
    task automatic txn(input int d, input point_t p, input point_t v[8], input bit skip_p,
                       input bit hold, input point_t np);
        int n, lat, lim;
        n = nv[d];
        lim = (n - 1) * (n - 2) + n + 1;
        lat = 0;
        if (!skip_p) send(d, p);
        for (int i = 0; i < n; i++) send(d, v[i]);
        q[d].push_back(model(n, p, v));
        while (!valid_of(d) && lat < lim + 4) begin
            if (hold) put(d, 1'b1, 10'($urandom), 10'($urandom));
            @(negedge clk);
            lat++;
        end
        chk("valid_seen", d, int'(valid_of(d)), 1);
        total++;
        if (lat >= lim || lat < 2 * n - 2) begin
            bad++;
            $display("FAIL latency dut%0d: got %0d cycles want %0d..%0d", d, lat, 2 * n - 2, lim - 1);
        end
        if (hold && valid_of(d)) begin
            put(d, 1'b1, np.x[9:0], np.y[9:0]);
            @(negedge clk);
            put(d, 1'b0, 10'd0, 10'd0);
        end
    endtask

    task automatic rand_txn(input int d);
        int tx [8], ty [8];
        int n, k, s, ox, oy, j;
        point_t v [8];
        point_t p, t;
        n = nv[d];
        case (d)
            0:       begin tx = '{0, 4, 2, 0, 0, 0, 0, 0}; ty = '{0, 0, 3, 0, 0, 0, 0, 0}; end
            1:       begin tx = '{1, 4, 3, 0, 0, 0, 0, 0}; ty = '{0, 1, 4, 3, 0, 0, 0, 0}; end
            default: begin tx = '{1, 3, 4, 3, 1, 0, 0, 0}; ty = '{0, 0, 2, 4, 4, 2, 0, 0}; end
        endcase
        k = $urandom_range(1, 60);
        s = 2 * k;
        ox = $urandom_range(3, 500);
        oy = $urandom_range(3, 500);
        for (int i = 0; i < 8; i++) v[i] = pt(tx[i] * s + ox, ty[i] * s + oy);
        if ($urandom_range(0, 3) == 0)
            p = pt((tx[0] + tx[1]) * k + ox, (ty[0] + ty[1]) * k + oy);
        else
            p = pt($urandom_range(ox - 2, ox + 4 * s + 2), $urandom_range(oy - 2, oy + 4 * s + 2));
        for (int i = n - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = v[i]; v[i] = v[j]; v[j] = t;
        end
        txn(d, p, v, 1'b0, 1'b0, p);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        point_t v [8];
        for (int d = 0; d < 3; d++) put(d, 1'b0, 10'd0, 10'd0);
        for (int i = 0; i < 8; i++) v[i] = pt(0, 0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_busy", d, int'(busy_of(d)), 0);
            chk("reset_valid", d, int'(valid_of(d)), 0);
            chk("reset_inside", d, int'(ins_of(d)), 0);
        end
        reset = 1'b0;

        // scrambled square
        v[0] = pt(0, 0); v[1] = pt(10, 10); v[2] = pt(10, 0); v[3] = pt(0, 10);
        txn(1, pt(5, 5), v, 1'b0, 1'b0, pt(0, 0));
        txn(1, pt(11, 5), v, 1'b0, 1'b0, pt(0, 0));
        txn(1, pt(10, 5), v, 1'b0, 1'b0, pt(0, 0));

        // hexagon fed clockwise, target at centroid
        v[0] = pt(200, 100); v[1] = pt(100, 300); v[2] = pt(200, 500);
        v[3] = pt(400, 500); v[4] = pt(500, 300); v[5] = pt(400, 100);
        txn(2, pt(300, 300), v, 1'b0, 1'b0, pt(0, 0));

        // full-range triangle
        v[0] = pt(0, 0); v[1] = pt(1023, 0); v[2] = pt(1023, 1023);
        txn(0, pt(1022, 1), v, 1'b0, 1'b0, pt(0, 0));
        txn(0, pt(1, 1022), v, 1'b0, 1'b0, pt(0, 0));

        // junk held through SORT/TEST; DONE-cycle sample becomes the next target
        v[0] = pt(10, 10); v[1] = pt(0, 0); v[2] = pt(0, 10); v[3] = pt(10, 0);
        txn(1, pt(5, 5), v, 1'b0, 1'b1, pt(11, 5));
        txn(1, pt(11, 5), v, 1'b1, 1'b1, pt(3, 7));
        txn(1, pt(3, 7), v, 1'b1, 1'b0, pt(0, 0));

        // reset pulsed mid-SORT
        v[0] = pt(200, 100); v[1] = pt(100, 300); v[2] = pt(200, 500);
        v[3] = pt(400, 500); v[4] = pt(500, 300); v[5] = pt(400, 100);
        send(2, pt(300, 300));
        for (int i = 0; i < 6; i++) send(2, v[i]);
        @(negedge clk);
        chk("busy_in_sort", 2, int'(busy_of(2)), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 2, int'(busy_of(2)), 0);
        chk("abort_valid", 2, int'(valid_of(2)), 0);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (40) @(negedge clk);
        txn(2, pt(450, 400), v, 1'b0, 1'b0, pt(0, 0));
        txn(2, pt(299, 301), v, 1'b0, 1'b0, pt(0, 0));

        for (int i = 0; i < 36; i++) rand_txn(i % 3);

        repeat (5) @(negedge clk);
        for (int d = 0; d < 3; d++) chk("drained", d, q[d].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
